xc20xx_config_loader: RTL and testbench
=======================================

Name: xc20xx_config_loader

Overview:
Serial configuration loader for the XC20XX fabric model. It deframes the bitstream shifted in on DIN and emits one parallel frame per FRAME_VALID pulse to the configuration memory. It sequences startup via GTS and GSR. Its GSR output drives the set/reset of every CLB storage element, flip-flop or D-latch, so it sits directly upstream of those primitives.

Parameters:
FRAME_BITS, 71, data bits per frame (excludes start and stop bits)
NUM_FRAMES, 160, frames per bitstream
ADDR_W, $clog2(NUM_FRAMES), FRAME_ADDR width

Ports:
CLK  input  1  configuration clock (CCLK); DIN sampled on rising edge
RST  input  1  asynchronous reset, active-high
DIN  input  1  serial bitstream
FRAME_DATA  output  FRAME_BITS  last completed frame; first-received data bit in MSB
FRAME_ADDR  output  ADDR_W  index of frame on FRAME_DATA, 0-based
FRAME_VALID  output  1  one-cycle pulse; frame data and address valid
DONE  output  1  configuration complete
ERR  output  1  sticky format/length error
GTS  output  1  global tristate, active-high
GSR  output  1  global set/reset to storage elements, active-high

Behaviour:
- Reset values (async, any time, including mid-frame): FRAME_DATA=0, FRAME_ADDR=0, FRAME_VALID=0, DONE=0, ERR=0, GTS=1, GSR=1; state SYNC; all counters 0.
- Bitstream format, MSB first: ≥4 ones, then 0010 (sync) | 24-bit length count | 1111 | NUM_FRAMES × (start 0, FRAME_BITS data, stop 111) | postamble 0111.
- States: SYNC, LEN, HTAIL, START, DATA, STOP, POST, SU1, SU2, SU3, CFGD, FAIL.
- SYNC: 8-bit history including current DIN equals 1111_0010 -> LEN next cycle. Other patterns are ignored; no error.
- LEN: 24 bits shifted into len_reg -> HTAIL. HTAIL: 4 bits; any 0 -> FAIL, else -> START.
- START: DIN=1 -> FAIL; DIN=0 -> DATA.
- DATA: FRAME_BITS bits into the shift register.
- STOP: 3 bits; any 0 -> FAIL.
- On the cycle after the third stop bit is sampled:
  - FRAME_DATA is updated.
  - FRAME_ADDR equals the frame index.
  - FRAME_VALID=1 for exactly one cycle.
  - Consumer must accept unconditionally; there is no backpressure.
- After the last stop bit: frame index NUM_FRAMES-1 -> POST, else -> START with index+1. FRAME_ADDR holds its value between frames.
- bit_cnt (24-bit) counts every bit from the first LEN bit through the last POST bit inclusive.
- POST: 4 bits must equal 0111; mismatch -> FAIL. On the last POST bit, bit_cnt (including that bit) ≠ len_reg -> FAIL.
- Success, with last POST bit sampled at cycle N:
  - N+1: DONE=1.
  - N+2: GTS=0.
  - N+3: GSR=0.
  - Then CFGD.
- CFGD: DIN ignored; outputs hold until RST.
- FAIL: ERR=1 on the cycle after the offending bit and stays sticky. No further FRAME_VALID pulses; DONE=0, GTS=1, GSR=1 held until RST.
- FRAME_VALID and any state transition never assert in the same cycle as RST.

Optional Feature:
XC20XX_CFG_LENCHECK_EN
- Defined: the length comparison in POST is active as above.
- Undefined: the length count is still shifted in and consumed, but never compared; only the format checks can cause FAIL. bit_cnt logic is removed.

Decomposition:
- Package xc20xx_cfg_pkg:
  - state enum cfg_state_t
  - SYNC_PATTERN = 8'b1111_0010
  - HTAIL_PATTERN = 4'b1111
  - POST_PATTERN = 4'b0111
  - LEN_W = 24
  - STOP_BITS = 3
- Sub-module xc20xx_cfg_shifter: FRAME_BITS shift register plus data-bit counter with load/done strobes. The FSM and startup sequencing stay in the top.

Test Plan:
All scenarios use FRAME_BITS=4, NUM_FRAMES=2; expected length = 24+4+2×8+4 = 48 (0x000030).
- Golden stream: 11110010, 0x000030, 1111, 0 1010 111, 0 0110 111, 0111 -> FRAME_VALID twice (ADDR 0 data 4'b1010, ADDR 1 data 4'b0110). DONE at N+1, GTS=0 at N+2, GSR=0 at N+3, ERR=0.
- Golden stream preceded by 20 idle ones and a noise pattern 1101 -> identical frames and startup timing (no error).
- Frame 1 second stop bit = 0 -> one FRAME_VALID (ADDR 0), ERR=1 next cycle, DONE=0, GSR=1 forever.
- Length field 0x000031 with LENCHECK_EN defined -> ERR=1 after last POST bit, DONE=0. Same stimulus with macro undefined -> DONE=1, ERR=0.
- RST pulsed during frame 0 DATA -> all outputs return to reset values immediately. A subsequent golden stream completes normally with FRAME_ADDR starting at 0.
- After CFGD, drive random DIN for 50 cycles -> DONE=1, GTS=0, GSR=0 held, no FRAME_VALID.

Source files
------------

// File: rtl/xc20xx_config_loader_pkg.sv
// xc20xx_cfg_pkg: shared types and constants for the XC20XX configuration loader.
//   cfg_state_t   - loader FSM states
//   SYNC_PATTERN  - 8-bit preamble tail that starts a bitstream
//   HTAIL_PATTERN - 4 bits that close the header after the length count
//   POST_PATTERN  - 4-bit postamble after the last frame
//   LEN_W         - width of the length-count field
//   STOP_BITS     - stop bits per frame
package xc20xx_cfg_pkg;

    typedef enum logic [3:0] {
        S_SYNC, S_LEN, S_HTAIL, S_START, S_DATA, S_STOP,
        S_POST, S_SU1, S_SU2, S_SU3, S_CFGD, S_FAIL
    } cfg_state_t;

    localparam logic [7:0] SYNC_PATTERN  = 8'b1111_0010;
    localparam logic [3:0] HTAIL_PATTERN = 4'b1111;
    localparam logic [3:0] POST_PATTERN  = 4'b0111;
    localparam int         LEN_W         = 24;
    localparam int         STOP_BITS     = 3;

endpackage

// File: rtl/xc20xx_config_loader_if.sv
// xc20xx_cfg_if: serial-in / frame-out bundle of the configuration loader.
//   DIN          - serial bitstream into the loader
//   FRAME_DATA   - last completed frame, first-received bit in MSB
//   FRAME_ADDR   - 0-based index of the frame on FRAME_DATA
//   FRAME_VALID  - one-cycle strobe, no backpressure
//   DONE/ERR     - configuration complete / sticky format or length error
//   GTS/GSR      - global tristate and global set/reset, active-high
// master: the loader.  slave: the configuration memory / fabric side.
interface xc20xx_cfg_if #(
    parameter int FRAME_BITS = 71,
    parameter int ADDR_W     = 8
);
    logic                  DIN;
    logic [FRAME_BITS-1:0] FRAME_DATA;
    logic [ADDR_W-1:0]     FRAME_ADDR;
    logic                  FRAME_VALID;
    logic                  DONE;
    logic                  ERR;
    logic                  GTS;
    logic                  GSR;

    modport master (
        input  DIN,
        output FRAME_DATA, FRAME_ADDR, FRAME_VALID, DONE, ERR, GTS, GSR
    );

    modport slave (
        output DIN,
        input  FRAME_DATA, FRAME_ADDR, FRAME_VALID, DONE, ERR, GTS, GSR
    );
endinterface

// File: rtl/xc20xx_config_loader_shifter.sv
// xc20xx_cfg_shifter: frame data shift register with data-bit counter.
//   i_clk, i_rst - clock, async active-high reset
//   i_shift      - load strobe: shift i_din in this cycle
//   i_din        - serial data bit
//   o_data       - shift register contents, first bit shifted in ends in MSB
//   o_done       - high while the last data bit of a frame is being shifted
module xc20xx_cfg_shifter #(
    parameter int FRAME_BITS = 71
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_shift,
    input  logic                  i_din,
    output logic [FRAME_BITS-1:0] o_data,
    output logic                  o_done
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic [FRAME_BITS-1:0] r_data;
    logic [CNT_W-1:0]      r_cnt;

    assign o_data = r_data;
    assign o_done = i_shift && (r_cnt == CNT_W'(FRAME_BITS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= {r_data[FRAME_BITS-2:0], i_din};
            r_cnt  <= o_done ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/xc20xx_config_loader.sv
// xc20xx_config_loader: deframes the serial XC20XX bitstream, emits one
// parallel frame per FRAME_VALID pulse and sequences startup (DONE, then GTS
// release, then GSR release).
//   CLK  - configuration clock, DIN sampled on rising edge
//   RST  - asynchronous reset, active-high
//   bus  - xc20xx_cfg_if.master (DIN in; frame, DONE, ERR, GTS, GSR out)
// Build option: XC20XX_CFG_LENCHECK_EN enables the bit-count vs. length-field
// comparison on the last postamble bit; without it the length field is only
// consumed and no bit counter exists.
module xc20xx_config_loader
    import xc20xx_cfg_pkg::*;
#(
    parameter int FRAME_BITS = 71,
    parameter int NUM_FRAMES = 160,
    parameter int ADDR_W     = $clog2(NUM_FRAMES)
) (
    input logic         CLK,
    input logic         RST,
    xc20xx_cfg_if.master bus
);
    cfg_state_t            r_state, w_next;
    logic [6:0]            r_hist;
    logic [4:0]            r_cnt;
    logic [ADDR_W-1:0]     r_idx;
    logic [FRAME_BITS-1:0] r_frame_data;
    logic [ADDR_W-1:0]     r_frame_addr;
    logic                  r_frame_valid;

    logic [FRAME_BITS-1:0] w_sh_data;
    logic                  w_sh_done;
    logic                  w_frame_end;
    logic                  w_len_ok;
    logic                  w_counting;
    logic [1:0]            w_nib;

    // Pattern bits are checked MSB first, so bit index = 3 - r_cnt.
    assign w_nib       = ~r_cnt[1:0];
    assign w_frame_end = (r_state == S_STOP) && bus.DIN &&
                         (r_cnt == 5'(STOP_BITS - 1));
    assign w_counting  = (r_state == S_LEN) || (r_state == S_HTAIL) ||
                         (r_state == S_STOP) || (r_state == S_POST);

    xc20xx_cfg_shifter #(.FRAME_BITS(FRAME_BITS)) u_shifter (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_shift (r_state == S_DATA),
        .i_din   (bus.DIN),
        .o_data  (w_sh_data),
        .o_done  (w_sh_done)
    );

`ifdef XC20XX_CFG_LENCHECK_EN
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_bit_cnt;
    logic             w_in_body;

    // Every bit from the first length bit through the last postamble bit.
    assign w_in_body = (r_state == S_LEN) || (r_state == S_HTAIL) ||
                       (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_STOP) || (r_state == S_POST);
    // r_bit_cnt does not yet include the bit being sampled, hence +1.
    assign w_len_ok  = (r_bit_cnt + LEN_W'(1)) == r_len;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_len     <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (r_state == S_LEN) r_len <= {r_len[LEN_W-2:0], bus.DIN};
            if (w_in_body)        r_bit_cnt <= r_bit_cnt + LEN_W'(1);
        end
    end
`else
    assign w_len_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_SYNC;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SYNC:  if ({r_hist, bus.DIN} == SYNC_PATTERN) w_next = S_LEN;
            S_LEN:   if (r_cnt == 5'(LEN_W - 1)) w_next = S_HTAIL;
            S_HTAIL: begin
                if (bus.DIN != HTAIL_PATTERN[w_nib]) w_next = S_FAIL;
                else if (r_cnt == 5'd3)              w_next = S_START;
            end
            S_START: w_next = bus.DIN ? S_FAIL : S_DATA;
            S_DATA:  if (w_sh_done) w_next = S_STOP;
            S_STOP: begin
                if (!bus.DIN) w_next = S_FAIL;
                else if (w_frame_end)
                    w_next = (r_idx == ADDR_W'(NUM_FRAMES - 1)) ? S_POST : S_START;
            end
            S_POST: begin
                if (bus.DIN != POST_PATTERN[w_nib]) w_next = S_FAIL;
                else if (r_cnt == 5'd3)             w_next = w_len_ok ? S_SU1 : S_FAIL;
            end
            S_SU1:   w_next = S_SU2;
            S_SU2:   w_next = S_SU3;
            S_SU3:   w_next = S_CFGD;
            S_CFGD:  w_next = S_CFGD;
            S_FAIL:  w_next = S_FAIL;
            default: w_next = S_FAIL;
        endcase
    end

    // Startup/status outputs decoded from state
    always_comb begin
        bus.DONE = 1'b0;
        bus.GTS  = 1'b1;
        bus.GSR  = 1'b1;
        bus.ERR  = 1'b0;
        case (r_state)
            S_SU1: bus.DONE = 1'b1;
            S_SU2: begin
                bus.DONE = 1'b1;
                bus.GTS  = 1'b0;
            end
            S_SU3, S_CFGD: begin
                bus.DONE = 1'b1;
                bus.GTS  = 1'b0;
                bus.GSR  = 1'b0;
            end
            S_FAIL: bus.ERR = 1'b1;
            default: ;
        endcase
    end

    // Datapath: sync history, field counter, frame index and frame outputs.
    // r_cnt restarts on every state change so each field counts from 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hist        <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_frame_data  <= '0;
            r_frame_addr  <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            if (r_state == S_SYNC) r_hist <= {r_hist[5:0], bus.DIN};

            if (w_next != r_state) r_cnt <= '0;
            else if (w_counting)   r_cnt <= r_cnt + 5'd1;

            r_frame_valid <= w_frame_end;
            if (w_frame_end) begin
                r_frame_data <= w_sh_data;
                r_frame_addr <= r_idx;
                if (r_idx != ADDR_W'(NUM_FRAMES - 1)) r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.FRAME_DATA  = r_frame_data;
    assign bus.FRAME_ADDR  = r_frame_addr;
    assign bus.FRAME_VALID = r_frame_valid;
endmodule

// File: tb/tb_xc20xx_config_loader.sv
module tb_xc20xx_config_loader;
    localparam int FB = 4;
    localparam int NF = 2;
    localparam int AW = $clog2(NF);

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    xc20xx_cfg_if #(.FRAME_BITS(FB), .ADDR_W(AW)) bus ();
    xc20xx_config_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [AW+FB-1:0] exp_q[$];
    logic [AW+FB-1:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every FRAME_VALID pops one expected {addr,data}.
    always @(negedge CLK) begin
        if (!RST && bus.FRAME_VALID === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected FRAME_VALID", 32'd1, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("frame addr", 32'(bus.FRAME_ADDR), 32'(mon_e[AW+FB-1:FB]));
                chk("frame data", 32'(bus.FRAME_DATA), 32'(mon_e[FB-1:0]));
            end
        end
    end

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge CLK);
            bus.DIN = v[i];
        end
    endtask

    task automatic send_frame(input logic [3:0] d, input int addr);
        send_bits(32'd0, 1);
        send_bits(32'(d), 4);
        exp_q.push_back({AW'(addr), d});
        send_bits(32'b111, 3);
    endtask

    task automatic golden_stream(input logic [23:0] len);
        send_bits(32'hF2, 8);
        send_bits(32'(len), 24);
        send_bits(32'hF, 4);
        send_frame(4'b1010, 0);
        send_frame(4'b0110, 1);
        send_bits(32'b0111, 4);
    endtask

    // Called right after the last postamble bit is driven (cycle N).
    task automatic expect_startup(input string tag);
        chk({tag, " DONE@N"}, 32'(bus.DONE), 32'd0);
        @(negedge CLK);
        chk({tag, " DONE@N+1"}, 32'(bus.DONE), 32'd1);
        chk({tag, " GTS@N+1"},  32'(bus.GTS),  32'd1);
        chk({tag, " GSR@N+1"},  32'(bus.GSR),  32'd1);
        @(negedge CLK);
        chk({tag, " GTS@N+2"},  32'(bus.GTS),  32'd0);
        chk({tag, " GSR@N+2"},  32'(bus.GSR),  32'd1);
        @(negedge CLK);
        chk({tag, " GTS@N+3"},  32'(bus.GTS),  32'd0);
        chk({tag, " GSR@N+3"},  32'(bus.GSR),  32'd0);
        chk({tag, " DONE@N+3"}, 32'(bus.DONE), 32'd1);
        chk({tag, " ERR"},      32'(bus.ERR),  32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " FRAME_DATA"},  32'(bus.FRAME_DATA),  32'd0);
        chk({tag, " FRAME_ADDR"},  32'(bus.FRAME_ADDR),  32'd0);
        chk({tag, " FRAME_VALID"}, 32'(bus.FRAME_VALID), 32'd0);
        chk({tag, " DONE"},        32'(bus.DONE),        32'd0);
        chk({tag, " ERR"},         32'(bus.ERR),         32'd0);
        chk({tag, " GTS"},         32'(bus.GTS),         32'd1);
        chk({tag, " GSR"},         32'(bus.GSR),         32'd1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.DIN = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        bus.DIN = 1'b1;
        repeat (2) @(negedge CLK);
        chk_reset("reset");
        RST = 1'b0;

        // Golden stream
        golden_stream(24'h000030);
        expect_startup("golden");
        chk("golden drained", 32'(exp_q.size()), 32'd0);

        // CFGD ignores DIN and holds outputs
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            bus.DIN = 1'($urandom);
            chk("cfgd DONE", 32'(bus.DONE), 32'd1);
            chk("cfgd GTS",  32'(bus.GTS),  32'd0);
            chk("cfgd GSR",  32'(bus.GSR),  32'd0);
        end
        chk("cfgd FRAME_DATA", 32'(bus.FRAME_DATA), 32'h6);
        chk("cfgd FRAME_ADDR", 32'(bus.FRAME_ADDR), 32'd1);

        // Asynchronous reset mid-cycle takes effect immediately
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 chk_reset("async rst cfgd");
        @(negedge CLK);
        RST = 1'b0;

        // Idle ones and noise ahead of the golden stream
        send_bits(32'hFFFFF, 20);
        send_bits(32'b1101, 4);
        golden_stream(24'h000030);
        expect_startup("noise");

        // Second stop bit of frame 1 is 0
        do_reset();
        send_bits(32'hF2, 8);
        send_bits(32'h30, 24);
        send_bits(32'hF, 4);
        send_frame(4'b1010, 0);
        send_bits(32'd0, 1);
        send_bits(32'b0110, 4);
        send_bits(32'b10, 2);
        chk("stoperr ERR@N", 32'(bus.ERR), 32'd0);
        @(negedge CLK);
        chk("stoperr ERR@N+1", 32'(bus.ERR), 32'd1);
        send_bits(32'b1, 1);
        send_bits(32'b0111, 4);
        repeat (5) @(negedge CLK);
        chk("stoperr ERR",  32'(bus.ERR),  32'd1);
        chk("stoperr DONE", 32'(bus.DONE), 32'd0);
        chk("stoperr GTS",  32'(bus.GTS),  32'd1);
        chk("stoperr GSR",  32'(bus.GSR),  32'd1);
        chk("stoperr FRAME_DATA", 32'(bus.FRAME_DATA), 32'hA);
        chk("stoperr drained", 32'(exp_q.size()), 32'd0);

        // Length field one too large
        do_reset();
        golden_stream(24'h000031);
`ifdef XC20XX_CFG_LENCHECK_EN
        chk("len ERR@N", 32'(bus.ERR), 32'd0);
        @(negedge CLK);
        chk("len ERR@N+1",  32'(bus.ERR),  32'd1);
        chk("len DONE@N+1", 32'(bus.DONE), 32'd0);
        repeat (3) @(negedge CLK);
        chk("len DONE", 32'(bus.DONE), 32'd0);
        chk("len GSR",  32'(bus.GSR),  32'd1);
`else
        expect_startup("len unchecked");
`endif

        // Reset during frame 0 DATA, then a clean stream
        do_reset();
        send_bits(32'hF2, 8);
        send_bits(32'h30, 24);
        send_bits(32'hF, 4);
        send_bits(32'b0, 1);
        send_bits(32'b10, 2);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 chk_reset("rst in data");
        @(negedge CLK);
        RST = 1'b0;
        send_bits(32'b10111, 5);
        chk("rst in data no frame", 32'(bus.FRAME_VALID), 32'd0);
        golden_stream(24'h000030);
        expect_startup("after rst");

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
